// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - integer register file with write bypass and busy-bit scoreboard
module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int ADDR_W  = $clog2(NREGS)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic [ADDR_W-1:0] rd,
    input  logic              rd_write_control,
    input  logic [XLEN-1:0]   rd_write_val,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_rd,
    input  logic              flush,
    output logic [XLEN-1:0]   rs1_val,
    output logic [XLEN-1:0]   rs2_val,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic              rsv_busy,
    output logic [ADDR_W:0]   busy_count
);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;
    logic             w_wr_en;
    logic             w_rs1_zero, w_rs2_zero, w_rsv_zero;
    logic             w_rs1_byp,  w_rs2_byp,  w_rsv_byp;
    logic [ADDR_W:0]  w_count;

    // Writes to a hardwired x0 are dropped before they reach storage or the bypass path
    assign w_wr_en = rd_write_control && !((ZERO_REG != 0) && (rd == '0));

    assign w_rs1_zero = (ZERO_REG != 0) && (rs1 == '0);
    assign w_rs2_zero = (ZERO_REG != 0) && (rs2 == '0);
    assign w_rsv_zero = (ZERO_REG != 0) && (rsv_rd == '0);

    assign w_rs1_byp = (BYPASS != 0) && w_wr_en && (rd == rs1);
    assign w_rs2_byp = (BYPASS != 0) && w_wr_en && (rd == rs2);
    assign w_rsv_byp = (BYPASS != 0) && w_wr_en && (rd == rsv_rd);

    always_comb begin
        rs1_val = r_regs[rs1];
        if (w_rs1_zero)
            rs1_val = '0;
        else if (w_rs1_byp)
            rs1_val = rd_write_val;
    end

    always_comb begin
        rs2_val = r_regs[rs2];
        if (w_rs2_zero)
            rs2_val = '0;
        else if (w_rs2_byp)
            rs2_val = rd_write_val;
    end

    // A producer writing back this cycle no longer blocks its consumers when bypass is on
    assign rs1_busy = r_busy[rs1]    && !w_rs1_zero && !w_rs1_byp;
    assign rs2_busy = r_busy[rs2]    && !w_rs2_zero && !w_rs2_byp;
    assign rsv_busy = r_busy[rsv_rd] && !w_rsv_zero && !w_rsv_byp;

    // Reserve is applied after release so a new in-flight producer wins on the same register
    always_comb begin
        w_busy_nxt = r_busy;
        if (flush) begin
            w_busy_nxt = '0;
        end else begin
            if (rd_write_control)
                w_busy_nxt[rd] = 1'b0;
            if (rsv_en && !w_rsv_zero)
                w_busy_nxt[rsv_rd] = 1'b1;
        end
    end

    always_comb begin
        w_count = '0;
        for (int i = 0; i < NREGS; i++)
            w_count = w_count + (ADDR_W + 1)'(r_busy[i]);
    end

    assign busy_count = w_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NREGS; i++)
                r_regs[i] <= '0;
            r_busy <= '0;
        end else begin
            if (w_wr_en)
                r_regs[rd] <= rd_write_val;
            r_busy <= w_busy_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed bench for regfile_sb, bypassed and non-bypassed instances
module tb_regfile_sb;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int ADDR_W = 5;

    logic              i_clk;
    logic              i_rst;
    logic [ADDR_W-1:0] rs1, rs2, rd, rsv_rd;
    logic              rd_write_control, rsv_en, flush;
    logic [XLEN-1:0]   rd_write_val;

    logic [XLEN-1:0]   b_rs1_val, b_rs2_val, n_rs1_val, n_rs2_val;
    logic              b_rs1_busy, b_rs2_busy, b_rsv_busy;
    logic              n_rs1_busy, n_rs2_busy, n_rsv_busy;
    logic [ADDR_W:0]   b_busy_count, n_busy_count;

    int vectors;
    int miscompares;

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(1), .BYPASS(1)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .rs1(rs1), .rs2(rs2), .rd(rd),
        .rd_write_control(rd_write_control), .rd_write_val(rd_write_val),
        .rsv_en(rsv_en), .rsv_rd(rsv_rd), .flush(flush),
        .rs1_val(b_rs1_val), .rs2_val(b_rs2_val), .rs1_busy(b_rs1_busy),
        .rs2_busy(b_rs2_busy), .rsv_busy(b_rsv_busy), .busy_count(b_busy_count)
    );

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .i_clk(i_clk), .i_rst(i_rst), .rs1(rs1), .rs2(rs2), .rd(rd),
        .rd_write_control(rd_write_control), .rd_write_val(rd_write_val),
        .rsv_en(rsv_en), .rsv_rd(rsv_rd), .flush(flush),
        .rs1_val(n_rs1_val), .rs2_val(n_rs2_val), .rs1_busy(n_rs1_busy),
        .rs2_busy(n_rs2_busy), .rsv_busy(n_rsv_busy), .busy_count(n_busy_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        rd_write_control = 1'b0;
        rsv_en           = 1'b0;
        flush            = 1'b0;
        rd               = '0;
        rd_write_val     = '0;
        rsv_rd           = '0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        rs1 = 5'd5; rs2 = 5'd9;
        idle();
        #2;
        vectors++;
        if (b_rs1_val !== 32'h0 || b_busy_count !== 6'd0 || b_rs1_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_init: val=%h cnt=%0d busy=%b, want 0/0/0", b_rs1_val, b_busy_count, b_rs1_busy);
        end
        tick();
        i_rst = 1'b0;
        rd_write_control = 1'b1; rd = 5'd5; rd_write_val = 32'hDEADBEEF;
        tick();
        idle();
        rsv_en = 1'b1; rsv_rd = 5'd5;
        tick();
        idle();
        #1;
        vectors++;
        if (b_rs1_val !== 32'hDEADBEEF || b_rs1_busy !== 1'b1 || b_busy_count !== 6'd1) begin
            miscompares++;
            $display("FAIL reset_pre: val=%h busy=%b cnt=%0d, want deadbeef/1/1", b_rs1_val, b_rs1_busy, b_busy_count);
        end
        i_rst = 1'b1;
        #1;
        vectors++;
        if (b_rs1_val !== 32'h0 || b_rs1_busy !== 1'b0 || b_busy_count !== 6'd0 || n_rs1_val !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_async: val=%h busy=%b cnt=%0d nb_val=%h, want 0/0/0/0", b_rs1_val, b_rs1_busy, b_busy_count, n_rs1_val);
        end
        #1;
        i_rst = 1'b0;
    endtask

    task automatic test_zero_reg();
        tick();
        rs1 = 5'd0;
        rd_write_control = 1'b1; rd = 5'd0; rd_write_val = 32'h12345678;
        #1;
        vectors++;
        if (b_rs1_val !== 32'h0) begin
            miscompares++;
            $display("FAIL zero_bypass: rs1_val=%h, want 0", b_rs1_val);
        end
        tick();
        idle();
        rsv_en = 1'b1; rsv_rd = 5'd0;
        #1;
        vectors++;
        if (b_rsv_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_rsv_busy: rsv_busy=%b, want 0", b_rsv_busy);
        end
        tick();
        idle();
        #1;
        vectors++;
        if (b_rs1_val !== 32'h0 || n_rs1_val !== 32'h0 || b_rs1_busy !== 1'b0 || b_busy_count !== 6'd0) begin
            miscompares++;
            $display("FAIL zero_after: val=%h nb_val=%h busy=%b cnt=%0d, want 0/0/0/0", b_rs1_val, n_rs1_val, b_rs1_busy, b_busy_count);
        end
    endtask

    task automatic test_bypass();
        rs1 = 5'd3; rs2 = 5'd3;
        rd_write_control = 1'b1; rd = 5'd3; rd_write_val = 32'hA5A5A5A5;
        #1;
        vectors++;
        if (b_rs1_val !== 32'hA5A5A5A5 || b_rs2_val !== 32'hA5A5A5A5) begin
            miscompares++;
            $display("FAIL bypass_same_cycle: rs1=%h rs2=%h, want a5a5a5a5", b_rs1_val, b_rs2_val);
        end
        vectors++;
        if (n_rs1_val !== 32'h0) begin
            miscompares++;
            $display("FAIL nobypass_same_cycle: rs1=%h, want 0", n_rs1_val);
        end
        tick();
        idle();
        #1;
        vectors++;
        if (b_rs1_val !== 32'hA5A5A5A5 || n_rs1_val !== 32'hA5A5A5A5 || n_rs2_val !== 32'hA5A5A5A5) begin
            miscompares++;
            $display("FAIL write_next_cycle: b=%h nb1=%h nb2=%h, want a5a5a5a5", b_rs1_val, n_rs1_val, n_rs2_val);
        end
        vectors++;
        if (b_busy_count !== 6'd0 || b_rs1_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL write_nonbusy: cnt=%0d busy=%b, want 0/0", b_busy_count, b_rs1_busy);
        end
    endtask

    task automatic test_scoreboard();
        rsv_en = 1'b1; rsv_rd = 5'd7;
        tick();
        idle();
        rs2 = 5'd7;
        #1;
        vectors++;
        if (b_rs2_busy !== 1'b1 || n_rs2_busy !== 1'b1 || b_busy_count !== 6'd1) begin
            miscompares++;
            $display("FAIL sb_reserved: busy=%b nb=%b cnt=%0d, want 1/1/1", b_rs2_busy, n_rs2_busy, b_busy_count);
        end
        rd_write_control = 1'b1; rd = 5'd7; rd_write_val = 32'h55;
        #1;
        vectors++;
        if (b_rs2_busy !== 1'b0 || b_rs2_val !== 32'h55 || n_rs2_busy !== 1'b1 || n_rs2_val !== 32'h0) begin
            miscompares++;
            $display("FAIL sb_release_cycle: busy=%b val=%h nb_busy=%b nb_val=%h, want 0/55/1/0", b_rs2_busy, b_rs2_val, n_rs2_busy, n_rs2_val);
        end
        tick();
        idle();
        #1;
        vectors++;
        if (b_busy_count !== 6'd0 || n_rs2_busy !== 1'b0 || n_rs2_val !== 32'h55) begin
            miscompares++;
            $display("FAIL sb_released: cnt=%0d nb_busy=%b nb_val=%h, want 0/0/55", b_busy_count, n_rs2_busy, n_rs2_val);
        end
    endtask

    task automatic test_reserve_release();
        rsv_en = 1'b1; rsv_rd = 5'd9;
        tick();
        idle();
        rd_write_control = 1'b1; rd = 5'd9; rd_write_val = 32'h99;
        rsv_en = 1'b1; rsv_rd = 5'd9;
        #1;
        vectors++;
        if (b_rsv_busy !== 1'b0 || n_rsv_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL rr_rsv_busy: b=%b nb=%b, want 0/1", b_rsv_busy, n_rsv_busy);
        end
        tick();
        idle();
        rs1 = 5'd9;
        #1;
        vectors++;
        if (b_rs1_busy !== 1'b1 || b_busy_count !== 6'd1 || b_rs1_val !== 32'h99) begin
            miscompares++;
            $display("FAIL rr_after: busy=%b cnt=%0d val=%h, want 1/1/99", b_rs1_busy, b_busy_count, b_rs1_val);
        end
        rd_write_control = 1'b1; rd = 5'd9; rd_write_val = 32'h99;
        tick();
        idle();
    endtask

    task automatic test_flush();
        rsv_en = 1'b1; rsv_rd = 5'd1;
        tick();
        rsv_rd = 5'd2;
        tick();
        rsv_rd = 5'd4;
        tick();
        idle();
        #1;
        vectors++;
        if (b_busy_count !== 6'd3 || n_busy_count !== 6'd3) begin
            miscompares++;
            $display("FAIL flush_pre: cnt=%0d nb=%0d, want 3", b_busy_count, n_busy_count);
        end
        flush = 1'b1;
        rsv_en = 1'b1; rsv_rd = 5'd6;
        rd_write_control = 1'b1; rd = 5'd10; rd_write_val = 32'hCAFE0010;
        tick();
        idle();
        rs1 = 5'd6; rs2 = 5'd10;
        #1;
        vectors++;
        if (b_busy_count !== 6'd0 || b_rs1_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_after: cnt=%0d x6_busy=%b, want 0/0", b_busy_count, b_rs1_busy);
        end
        vectors++;
        if (b_rs2_val !== 32'hCAFE0010 || n_rs2_val !== 32'hCAFE0010) begin
            miscompares++;
            $display("FAIL flush_write: b=%h nb=%h, want cafe0010", b_rs2_val, n_rs2_val);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            rd_write_control = 1'b1;
            rd = ADDR_W'(11 + i);
            rd_write_val = 32'h1000_0000 + 32'(i);
            tick();
        end
        idle();
        rsv_en = 1'b1; rsv_rd = 5'd31;
        tick();
        idle();
        rsv_rd = 5'd31;
        rs1 = 5'd11; rs2 = 5'd14;
        #1;
        vectors++;
        if (b_rs1_val !== 32'h1000_0000 || b_rs2_val !== 32'h1000_0003) begin
            miscompares++;
            $display("FAIL b2b_read: x11=%h x14=%h, want 10000000/10000003", b_rs1_val, b_rs2_val);
        end
        vectors++;
        if (b_rsv_busy !== 1'b1 || b_busy_count !== 6'd1) begin
            miscompares++;
            $display("FAIL b2b_waw: rsv_busy=%b cnt=%0d, want 1/1", b_rsv_busy, b_busy_count);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_zero_reg();
        test_bypass();
        test_scoreboard();
        test_reserve_release();
        test_flush();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
